// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared types for the data-memory responder and the load/store
//               unit: request/response structs, memory op codes, access-size
//               codes, responder FSM state encoding and default latency.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        MEM_LOAD   = 2'd1,
        MEM_STORE  = 2'd2,
        MEM_ATOMIC = 2'd3
    } mem_op_t;

    // Access size codes carried in mem_request_t.size
    localparam logic [1:0] c_SIZE_BYTE    = 2'd0;
    localparam logic [1:0] c_SIZE_HALF    = 2'd1;
    localparam logic [1:0] c_SIZE_WORD    = 2'd2;
    localparam logic [1:0] c_SIZE_ILLEGAL = 2'd3;

    typedef struct packed {
        logic        valid;
        mem_op_t     op;
        logic [1:0]  size;
        logic        sign_extend;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_request_t;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [31:0] rdata;
    } mem_response_t;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_WAIT = 2'd1,
        MRS_RESP = 2'd2
    } mem_resp_state_t;

    localparam int MEM_RESP_LATENCY = 2;

endpackage
`default_nettype wire

// File: rtl/mem_data_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_align
// Description : Combinational lane handling for 32-bit little-endian memory.
//               Extracts and sign/zero-extends load data, and builds store
//               byte enables plus the merged write word. Flags misaligned
//               or illegal-size accesses.
// Ports       : i_size        access size code
//               i_addr_lo     byte offset within the word
//               i_sign_extend replicate MSB on byte/half loads
//               i_load_word   full word read from memory
//               i_store_data  store data (low bits significant)
//               i_old_word    current memory word for the merge
//               o_load_data   extracted/extended load result
//               o_byte_en     byte lanes written by a store
//               o_merged_word old word with enabled lanes replaced
//               o_misaligned  alignment violation or illegal size
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_align
    import mem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign_extend,
    input  logic [31:0] i_load_word,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_load_data,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_merged_word,
    output logic        o_misaligned
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic [31:0] w_store_shifted;

    // Byte offset scaled to a bit shift: lane data moves to/from bit 0
    assign w_shamt         = {i_addr_lo, 3'b000};
    assign w_lane          = i_load_word >> w_shamt;
    assign w_store_shifted = i_store_data << w_shamt;

    always_comb begin
        o_load_data  = 32'd0;
        o_byte_en    = 4'b0000;
        o_misaligned = 1'b0;
        case (i_size)
            c_SIZE_BYTE: begin
                o_load_data = {{24{i_sign_extend & w_lane[7]}}, w_lane[7:0]};
                o_byte_en   = 4'b0001 << i_addr_lo;
            end
            c_SIZE_HALF: begin
                o_load_data  = {{16{i_sign_extend & w_lane[15]}}, w_lane[15:0]};
                o_byte_en    = 4'b0011 << i_addr_lo;
                o_misaligned = i_addr_lo[0];
            end
            c_SIZE_WORD: begin
                o_load_data  = i_load_word;
                o_byte_en    = 4'b1111;
                o_misaligned = |i_addr_lo;
            end
            default: begin
                o_misaligned = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign o_merged_word[8*i +: 8] = o_byte_en[i] ? w_store_shifted[8*i +: 8]
                                                      : i_old_word[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-port data-memory target. Accepts one request at a
//               time, waits a fixed LATENCY, applies the load/store/atomic
//               effect and returns a one-cycle response strobe.
// Ports       : clk        clock
//               rst        asynchronous active-high reset
//               req_i      request (valid, op, size, sign_extend, addr, wdata)
//               resp_o     response (ready, valid strobe, rdata)
//               resp_err_o error flag qualifying resp_o.valid
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 65536,
    parameter int AW             = 16,
    parameter int LATENCY        = MEM_RESP_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    input  mem_request_t  req_i,
    output mem_response_t resp_o,
    output logic          resp_err_o
);

    localparam int         c_WORDS    = MEM_SIZE_BYTES / 4;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    mem_resp_state_t r_state;
    mem_resp_state_t w_state_next;
    logic [3:0]      r_cnt;

    mem_op_t         r_op;
    logic [1:0]      r_size;
    logic            r_sext;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [31:0]     r_mem [c_WORDS];

    logic            w_ready;
    logic            w_accept;
    logic            w_effect;
    logic [AW-3:0]   w_word_idx;
    logic [31:0]     w_old_word;
    logic [31:0]     w_load_data;
    logic [3:0]      w_byte_en;
    logic [31:0]     w_merged_word;
    logic            w_misaligned;
    logic            w_err;
    logic            w_write_en;
    logic [31:0]     w_write_word;
    logic [31:0]     w_rdata_eff;
    logic            w_unused_addr_hi;

    // Upper address bits are ignored so accesses wrap within the memory
    assign w_unused_addr_hi = ^req_i.addr[31:AW];

    assign w_ready    = (r_state == MRS_IDLE) && !rst;
    assign w_accept   = req_i.valid && w_ready && (req_i.op != MEM_NONE);
    assign w_effect   = (r_state == MRS_WAIT) && (r_cnt == 4'd0);
    assign w_word_idx = r_addr[AW-1:2];
    assign w_old_word = r_mem[w_word_idx];

    mem_data_align u_align (
        .i_size        (r_size),
        .i_addr_lo     (r_addr[1:0]),
        .i_sign_extend (r_sext),
        .i_load_word   (w_old_word),
        .i_store_data  (r_wdata),
        .i_old_word    (w_old_word),
        .o_load_data   (w_load_data),
        .o_byte_en     (w_byte_en),
        .o_merged_word (w_merged_word),
        .o_misaligned  (w_misaligned)
    );

    // Atomic add is defined for words only
    assign w_err = w_misaligned || ((r_op == MEM_ATOMIC) && (r_size != c_SIZE_WORD));

    assign w_write_en   = w_effect && !w_err && ((r_op == MEM_STORE) || (r_op == MEM_ATOMIC));
    assign w_write_word = (r_op == MEM_ATOMIC) ? (w_old_word + r_wdata) : w_merged_word;

    always_comb begin
        w_rdata_eff = 32'd0;
        if (!w_err) begin
            case (r_op)
                MEM_LOAD:   w_rdata_eff = w_load_data;
                MEM_ATOMIC: w_rdata_eff = w_old_word;
                default:    w_rdata_eff = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MRS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MRS_IDLE: if (w_accept) w_state_next = MRS_WAIT;
            MRS_WAIT: if (r_cnt == 4'd0) w_state_next = MRS_RESP;
            MRS_RESP: w_state_next = MRS_IDLE;
            default:  w_state_next = MRS_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, latency counter and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_op    <= MEM_NONE;
            r_size  <= 2'd0;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_CNT_INIT;
                r_op    <= req_i.op;
                r_size  <= req_i.size;
                r_sext  <= req_i.sign_extend;
                r_addr  <= req_i.addr[AW-1:0];
                r_wdata <= req_i.wdata;
            end else if ((r_state == MRS_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_effect) begin
                r_rdata <= w_rdata_eff;
                r_err   <= w_err;
            end
        end
    end

    // Storage is not reset; writes only happen from WAIT, which reset clears
    always_ff @(posedge clk) begin
        if (w_write_en) begin
            r_mem[w_word_idx] <= w_write_word;
        end
    end

    always_comb begin
        resp_o.ready = w_ready;
        resp_o.valid = (r_state == MRS_RESP);
        resp_o.rdata = r_rdata;
    end

    assign resp_err_o = r_err && (r_state == MRS_RESP);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Two instances are
//               exercised: LATENCY=2 and LATENCY=1. Expected responses are
//               queued when a request is accepted and compared when the
//               response strobe appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic          clk = 1'b0;
    logic          rst0;
    logic          rst1;
    mem_request_t  req0;
    mem_request_t  req1;
    mem_response_t resp0;
    mem_response_t resp1;
    logic          err0;
    logic          err1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.MEM_SIZE_BYTES(65536), .AW(16), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst0), .req_i(req0), .resp_o(resp0), .resp_err_o(err0)
    );

    mem_responder #(.MEM_SIZE_BYTES(65536), .AW(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .req_i(req1), .resp_o(resp1), .resp_err_o(err1)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Response monitors: pop one expectation per response strobe
    always @(negedge clk) begin
        if (resp0.valid === 1'b1) begin
            if (q0.size() == 0) begin
                check_value("dut0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check_value("dut0_rdata", resp0.rdata, e.rdata);
                check_value("dut0_err", {31'd0, err0}, {31'd0, e.err});
                check_value("dut0_latency", 32'(cyc - e.acc), 32'd2);
            end
        end else begin
            check_value("dut0_err_without_valid", {31'd0, err0}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (resp1.valid === 1'b1) begin
            if (q1.size() == 0) begin
                check_value("dut1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check_value("dut1_rdata", resp1.rdata, e.rdata);
                check_value("dut1_err", {31'd0, err1}, {31'd0, e.err});
                check_value("dut1_latency", 32'(cyc - e.acc), 32'd1);
            end
        end else begin
            check_value("dut1_err_without_valid", {31'd0, err1}, 32'd0);
        end
    end

    function automatic logic rdy(input bit sel);
        return sel ? resp1.ready : resp0.ready;
    endfunction

    // Issue one request, queue its expected response, and measure how long
    // ready stays low afterwards.
    task automatic do_req(input bit sel, input mem_op_t op, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        mem_request_t r;
        exp_t         e;
        int           n;
        bit           seen;
        r = '{valid: 1'b1, op: op, size: size, sign_extend: sext, addr: addr, wdata: wdata};
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = rdy(sel);
        end
        if (!seen) begin
            check_value("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (sel) req1 = r; else req0 = r;
        @(posedge clk);
        #1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        if (sel) begin
            req1.valid = 1'b0;
            q1.push_back(e);
        end else begin
            req0.valid = 1'b0;
            q0.push_back(e);
        end
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rdy(sel)) seen = 1'b1;
            else n++;
        end
        check_value(sel ? "dut1_ready_low_cycles" : "dut0_ready_low_cycles",
                    32'(n), sel ? 32'd2 : 32'd3);
    endtask

    // Accept a store, reset before its effect edge, then confirm it vanished
    task automatic rst_test(input bit sel);
        mem_request_t r;
        do_req(sel, MEM_STORE, c_SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0);
        r = '{valid: 1'b1, op: MEM_STORE, size: c_SIZE_WORD, sign_extend: 1'b0,
              addr: 32'h300, wdata: 32'h1};
        if (sel) req1 = r; else req0 = r;
        @(posedge clk);
        #1;
        if (sel) req1.valid = 1'b0; else req0.valid = 1'b0;
        check_value("rst_store_accepted", {31'd0, rdy(sel)}, 32'd0);
        @(negedge clk);
        if (sel) rst1 = 1'b1; else rst0 = 1'b1;
        #1;
        check_value("ready_during_rst", {31'd0, rdy(sel)}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (sel) rst1 = 1'b0; else rst0 = 1'b0;
        #1;
        check_value("ready_after_rst", {31'd0, rdy(sel)}, 32'd1);
        do_req(sel, MEM_LOAD, c_SIZE_WORD, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        req0 = '0;
        req1 = '0;
        #1;
        check_value("reset_ready", {31'd0, resp0.ready}, 32'd0);
        check_value("reset_valid", {31'd0, resp0.valid}, 32'd0);
        check_value("reset_rdata", resp0.rdata, 32'd0);
        check_value("reset_err", {31'd0, err0}, 32'd0);
        check_value("reset_ready1", {31'd0, resp1.ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        #1;
        check_value("ready_after_init", {31'd0, resp0.ready}, 32'd1);

        // Word store and wrapped-address load
        do_req(0, MEM_STORE, c_SIZE_WORD, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req(0, MEM_LOAD,  c_SIZE_WORD, 1'b0, 32'h0001_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Sub-word loads
        do_req(0, MEM_LOAD, c_SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'hFFFF_FFDE, 1'b0);
        do_req(0, MEM_LOAD, c_SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h0000_00DE, 1'b0);
        do_req(0, MEM_LOAD, c_SIZE_HALF, 1'b1, 32'h102, 32'h0, 32'hFFFF_DEAD, 1'b0);
        do_req(0, MEM_LOAD, c_SIZE_HALF, 1'b0, 32'h102, 32'h0, 32'h0000_DEAD, 1'b0);
        do_req(0, MEM_LOAD, c_SIZE_BYTE, 1'b1, 32'h100, 32'h0, 32'hFFFF_FFEF, 1'b0);

        // Sub-word stores
        do_req(0, MEM_STORE, c_SIZE_BYTE, 1'b0, 32'h101, 32'h1234_5655, 32'h0, 1'b0);
        do_req(0, MEM_LOAD,  c_SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEAD_55EF, 1'b0);
        do_req(0, MEM_STORE, c_SIZE_HALF, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 1'b0);
        do_req(0, MEM_LOAD,  c_SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hBEEF_55EF, 1'b0);

        // Atomic add, including wrap to zero
        do_req(0, MEM_STORE,  c_SIZE_WORD, 1'b0, 32'h200, 32'd10, 32'h0, 1'b0);
        do_req(0, MEM_ATOMIC, c_SIZE_WORD, 1'b0, 32'h200, 32'd5, 32'd10, 1'b0);
        do_req(0, MEM_LOAD,   c_SIZE_WORD, 1'b0, 32'h200, 32'h0, 32'd15, 1'b0);
        do_req(0, MEM_ATOMIC, c_SIZE_WORD, 1'b0, 32'h200, 32'hFFFF_FFF1, 32'd15, 1'b0);
        do_req(0, MEM_LOAD,   c_SIZE_WORD, 1'b0, 32'h200, 32'h0, 32'd0, 1'b0);

        // Error cases: no memory effect, rdata 0
        do_req(0, MEM_LOAD,   c_SIZE_WORD,    1'b0, 32'h102, 32'h0, 32'h0, 1'b1);
        do_req(0, MEM_LOAD,   c_SIZE_HALF,    1'b0, 32'h101, 32'h0, 32'h0, 1'b1);
        do_req(0, MEM_LOAD,   c_SIZE_ILLEGAL, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
        do_req(0, MEM_STORE,  c_SIZE_WORD,    1'b0, 32'h101, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(0, MEM_STORE,  c_SIZE_ILLEGAL, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_req(0, MEM_ATOMIC, c_SIZE_HALF,    1'b0, 32'h200, 32'd7, 32'h0, 1'b1);
        do_req(0, MEM_LOAD,   c_SIZE_WORD,    1'b0, 32'h100, 32'h0, 32'hBEEF_55EF, 1'b0);
        do_req(0, MEM_LOAD,   c_SIZE_WORD,    1'b0, 32'h200, 32'h0, 32'h0, 1'b0);

        // MEM_NONE with valid held: never accepted, no response
        @(negedge clk);
        req0 = '{valid: 1'b1, op: MEM_NONE, size: c_SIZE_WORD, sign_extend: 1'b0,
                 addr: 32'h100, wdata: 32'h0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("none_ready", {31'd0, resp0.ready}, 32'd1);
        end
        req0.valid = 1'b0;

        // Reset in the middle of a store
        rst_test(0);

        // LATENCY=1 instance
        do_req(1, MEM_STORE, c_SIZE_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0);
        do_req(1, MEM_LOAD,  c_SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);
        do_req(1, MEM_LOAD,  c_SIZE_HALF, 1'b0, 32'h42, 32'h0, 32'h0000_CAFE, 1'b0);
        rst_test(1);

        repeat (5) @(negedge clk);
        check_value("dut0_pending", 32'(q0.size()), 32'd0);
        check_value("dut1_pending", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
